// File: rtl/acx_irq_msg_scheduler.sv
// Round-robin scheduler that turns read-to-clear interrupt level vectors into
// one-shot messages, with per-source arming and a holdoff gap between messages.
//
// state | meaning
// IDLE  | waiting for an eligible source; grants the next one in RR order
// SEND  | message presented, held stable until the downstream accepts it
// HOLD  | holdoff gap after an accepted message, no grants
module acx_irq_msg_scheduler #(
  parameter int NUM_SRC        = 4,
  parameter int SRC_ID_WIDTH   = 2,
  parameter int TGT_DATA_WIDTH = 32,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [NUM_SRC*TGT_DATA_WIDTH-1:0] i_irq,
  input  logic [NUM_SRC-1:0]                i_enable,
  input  logic                              i_msg_ready,
  output logic                              o_msg_valid,
  output logic [SRC_ID_WIDTH-1:0]           o_msg_src,
  output logic [TGT_DATA_WIDTH-1:0]         o_msg_vector,
  output logic [NUM_SRC-1:0]                o_pending,
  output logic                              o_busy
);

  localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_HOLD} state_t;

  state_t                    state_q, state_d;
  logic [TGT_DATA_WIDTH-1:0] irq_q  [NUM_SRC];
  logic [TGT_DATA_WIDTH-1:0] snap_q [NUM_SRC];
  logic [NUM_SRC-1:0]        armed_q;
  logic [NUM_SRC-1:0]        elig;
  logic [SRC_ID_WIDTH-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]          hold_cnt_q;

  logic                      grant_hit;
  logic [SRC_ID_WIDTH-1:0]   grant_idx;
  logic [SRC_ID_WIDTH-1:0]   grant_nxt;
  logic [TGT_DATA_WIDTH-1:0] grant_vec;
  logic                      grant;
  logic                      xfer;

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      elig[k] = i_enable[k] & armed_q[k] & (|irq_q[k]);
    end
  end

  assign o_pending = elig;
  assign o_busy    = (state_q != ST_IDLE);

  // Offset i from the pointer is tried before offset i+1, giving wrap-around RR order.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    grant_nxt = '0;
    grant_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!grant_hit && elig[k] && (k == (int'(rr_ptr_q) + i) % NUM_SRC)) begin
          grant_hit = 1'b1;
          grant_idx = SRC_ID_WIDTH'(k);
          grant_nxt = SRC_ID_WIDTH'((k + 1) % NUM_SRC);
          grant_vec = irq_q[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_hit) begin
          grant   = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_msg_ready) begin
          xfer    = 1'b1;
          state_d = (HOLDOFF_CYCLES > 0) ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_msg_valid  <= 1'b0;
      o_msg_src    <= '0;
      o_msg_vector <= '0;
      rr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      armed_q      <= '1;
      for (int k = 0; k < NUM_SRC; k++) begin
        irq_q[k]  <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        irq_q[k] <= i_irq[k*TGT_DATA_WIDTH +: TGT_DATA_WIDTH];
      end

      if (grant) begin
        o_msg_valid  <= 1'b1;
        o_msg_src    <= grant_idx;
        o_msg_vector <= grant_vec;
        rr_ptr_q     <= grant_nxt;
      end else if (xfer) begin
        o_msg_valid <= 1'b0;
      end

      if (xfer) begin
        hold_cnt_q <= HOLD_LOAD;
      end else if (state_q == ST_HOLD && hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
      end

      // The sent source stays armed only if bits beyond the sent snapshot are already set.
      for (int k = 0; k < NUM_SRC; k++) begin
        if (xfer && o_msg_src == SRC_ID_WIDTH'(k)) begin
          snap_q[k]  <= o_msg_vector;
          armed_q[k] <= |(irq_q[k] & ~o_msg_vector);
        end else if ((irq_q[k] == '0) || (|(irq_q[k] & ~snap_q[k]))) begin
          armed_q[k] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acx_irq_msg_scheduler.sv
// Scoreboard bench: stimulus pushes expected messages, a negedge monitor pops
// and checks source, vector and arrival cycle, and checks hold stability.
module tb_acx_irq_msg_scheduler;

  localparam int NS = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NS*W-1:0] irq = '0;
  logic [NS-1:0]   en  = '1;
  logic            rdy = 1'b1;
  logic            msg_valid;
  logic [1:0]      msg_src;
  logic [W-1:0]    msg_vec;
  logic [NS-1:0]   pending;
  logic            busy;

  acx_irq_msg_scheduler #(
    .NUM_SRC(NS), .SRC_ID_WIDTH(2), .TGT_DATA_WIDTH(W), .HOLDOFF_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_irq(irq), .i_enable(en), .i_msg_ready(rdy),
    .o_msg_valid(msg_valid), .o_msg_src(msg_src), .o_msg_vector(msg_vec),
    .o_pending(pending), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]   src;
    logic [W-1:0] vec;
    int           at;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rel   = 0;
  int   n     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input int src, input logic [W-1:0] vec, input int at);
    exp_t e;
    e.src = 2'(src);
    e.vec = vec;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [W-1:0] v);
    irq[k*W +: W] = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
      check("rst_valid", 64'(msg_valid), 64'd0);
      check("rst_src", 64'(msg_src), 64'd0);
      check("rst_vec", 64'(msg_vec), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    rst = 1'b0;
    rel = cyc;
  endtask

  // Monitor
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [1:0]   held_src   = '0;
  logic [W-1:0] held_vec   = '0;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (msg_valid === 1'b1 && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_msg: got src=%0d vec=%0h want none (cycle %0d)",
                   msg_src, msg_vec, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("msg_src", 64'(msg_src), 64'(e.src));
          check("msg_vec", 64'(msg_vec), 64'(e.vec));
          check("msg_cycle", 64'(cyc), 64'(e.at));
        end
        held_src = msg_src;
        held_vec = msg_vec;
      end else if (prev_valid && !prev_ready) begin
        check("hold_valid", 64'(msg_valid), 64'd1);
        check("hold_src", 64'(msg_src), 64'(held_src));
        check("hold_vec", 64'(msg_vec), 64'(held_vec));
      end
      prev_valid = (msg_valid === 1'b1);
      prev_ready = rdy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a nonzero vector held: reported once at release+2
    set_src(3, 32'h5);
    do_reset();
    push(3, 32'h5, rel + 2);
    step(15);
    check("t1_pending", 64'(pending), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);

    // Single source, then clear and new value
    irq = '0;
    do_reset();
    step(1);
    set_src(2, 32'h10);
    n = cyc;
    push(2, 32'h10, n + 2);
    step(20);
    check("t2_pending", 64'(pending), 64'd0);
    set_src(2, 32'h0);
    step(3);
    set_src(2, 32'h20);
    n = cyc;
    push(2, 32'h20, n + 2);
    step(15);

    // Round robin, all sources together
    irq = '0;
    do_reset();
    step(1);
    for (int k = 0; k < NS; k++) set_src(k, 32'h1);
    n = cyc;
    for (int k = 0; k < NS; k++) push(k, 32'h1, n + 2 + 6 * k);
    step(30);
    check("t3_pending", 64'(pending), 64'd0);
    check("t3_busy", 64'(busy), 64'd0);

    // Backpressure; vector grows while the first message is held
    irq = '0;
    rdy = 1'b0;
    do_reset();
    step(1);
    set_src(1, 32'h10);
    n = cyc;
    push(1, 32'h10, n + 2);
    step(3);
    check("t4_pending", 64'(pending), 64'b0010);
    check("t4_busy", 64'(busy), 64'd1);
    step(2);
    set_src(1, 32'h30);
    step(7);
    rdy = 1'b1;
    push(1, 32'h30, n + 18);
    step(20);
    check("t4_pending_end", 64'(pending), 64'd0);

    // Masking
    irq = '0;
    en  = 4'b1110;
    do_reset();
    step(1);
    set_src(0, 32'h1);
    step(6);
    check("t5_masked_pending", 64'(pending), 64'd0);
    check("t5_masked_busy", 64'(busy), 64'd0);
    step(1);
    en = 4'b1111;
    n  = cyc;
    push(0, 32'h1, n + 1);
    #1;
    check("t5_enabled_pending", 64'(pending), 64'b0001);
    step(12);

    // Reset mid-SEND drops the message; it is re-reported after release
    irq = '0;
    rdy = 1'b0;
    do_reset();
    step(1);
    set_src(2, 32'h7);
    n = cyc;
    push(2, 32'h7, n + 2);
    step(4);
    check("t6_valid_before", 64'(msg_valid), 64'd1);
    check("t6_src_before", 64'(msg_src), 64'd2);
    do_reset();
    push(2, 32'h7, rel + 2);
    step(5);
    rdy = 1'b1;
    step(15);
    check("t6_busy_end", 64'(busy), 64'd0);
    check("t6_pending_end", 64'(pending), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
